// File: rtl/sevseg_pkg.sv
// Shared constants and types for the seven-segment scan driver family.
package sevseg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned DISP_W     = NUM_DIGITS * DIGIT_W;
    localparam int unsigned SEL_W      = 4;

    // Out-of-range select code; the segment-control stage turns all anodes off.
    localparam logic [SEL_W-1:0] SEL_OFF = 4'b1000;

    typedef logic [2:0] digit_idx_t;
    typedef logic [DISP_W-1:0] disp_word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/sevseg_prescaler.sv
// Free-running divider: pcnt counts 0..DIV-1, tick is high while pcnt==DIV-1.
module sevseg_prescaler #(
    parameter int unsigned DIV = 100000,
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          tick,
    output logic [CW-1:0] pcnt
);

    logic [CW-1:0] pcnt_nxt;

    always_comb begin
        pcnt_nxt = tick ? '0 : pcnt + CW'(1);
    end

    // tick is registered against the next count so it coincides with pcnt==DIV-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            pcnt <= pcnt_nxt;
            tick <= (pcnt_nxt == CW'(DIV - 1));
        end
    end

endmodule

// File: rtl/sevseg_scan_driver.sv
// Scan sequencer for an 8-digit display: digit index stepping, blanking,
// and a tear-free display buffer committed only at frame boundaries.
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [DISP_W-1:0]     load_data,
    output logic                  load_ready,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [SEL_W-1:0]      LED_Select,
    output logic [DISP_W-1:0]     data_out,
    output logic                  frame_start
);

    localparam int unsigned PCW = $clog2(REFRESH_DIV);

    scan_state_t    state, state_nxt;
    logic           tick;
    logic [PCW-1:0] pcnt;
    digit_idx_t     idx;
    logic           pend, pend_nxt;
    disp_word_t     pend_data;
    logic           wrap_c, accept_c, commit_c, blank_c;
    logic [SEL_W-1:0] sel_c;

    sevseg_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .pcnt (pcnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_SCAN;
            ST_SCAN: state_nxt = ST_SCAN;
        endcase
    end

    // Handshake and commit decode; accept and commit never coincide since ready == !pend.
    always_comb begin
        wrap_c   = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));
        accept_c = load_valid && load_ready;
        commit_c = wrap_c && pend;
        pend_nxt = pend;
        if (commit_c) pend_nxt = 1'b0;
        if (accept_c) pend_nxt = 1'b1;
        blank_c  = (32'(pcnt) < BLANK_CYCLES);
        sel_c    = SEL_OFF;
        if ((state == ST_SCAN) && !blank_c && digit_en[idx]) sel_c = {1'b0, idx};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx         <= '0;
            pend        <= 1'b0;
            pend_data   <= '0;
            data_out    <= '0;
            load_ready  <= 1'b1;
            frame_start <= 1'b0;
            LED_Select  <= SEL_OFF;
        end else begin
            if (tick) idx <= idx + digit_idx_t'(1);
            if (accept_c) pend_data <= load_data;
            if (commit_c) data_out <= pend_data;
            pend        <= pend_nxt;
            load_ready  <= !pend_nxt;
            frame_start <= wrap_c;
            LED_Select  <= sel_c;
        end
    end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Scoreboard bench for sevseg_scan_driver with REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_sevseg_scan_driver;
    import sevseg_pkg::*;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 1;
    localparam int          FRAME = DIV * NUM_DIGITS;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic [7:0]  digit_en = 8'hFF;
    logic        load_ready;
    logic        frame_start;
    logic [3:0]  LED_Select;
    logic [31:0] data_out;

    always #5 clk = ~clk;

    sevseg_scan_driver #(
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .digit_en    (digit_en),
        .LED_Select  (LED_Select),
        .data_out    (data_out),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [3:0]  sel;
        logic        ready;
        logic [31:0] data;
        logic        frame;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_data = '0;
    logic [31:0] m_data = '0;
    logic        last_acc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t, cyc=%0d)", name, act, req, $time, cyc);
    endtask

    // Expected select after edge n: slot position and digit derived from the edge count.
    function automatic logic [3:0] exp_sel(input int n, input logic [7:0] en);
        int pc;
        int ix;
        pc = (n - 1) % int'(DIV);
        ix = ((n - 1) / int'(DIV)) % int'(NUM_DIGITS);
        if (pc < int'(BLANK) || !en[ix]) return SEL_OFF;
        return 4'(ix);
    endfunction

    // One clock of stimulus: model the edge, then queue what the DUT must show after it.
    task automatic step();
        logic [7:0]  en;
        logic [31:0] ld;
        logic        acc;
        logic        wrap;
        exp_t        e;
        en   = digit_en;
        ld   = load_data;
        acc  = load_valid && !m_pend;
        wrap = ((cyc + 1) % FRAME) == 0;
        @(posedge clk);
        #1;
        cyc++;
        if (wrap && m_pend) begin
            m_data = m_pend_data;
            m_pend = 1'b0;
        end
        if (acc) begin
            m_pend      = 1'b1;
            m_pend_data = ld;
        end
        last_acc = acc;
        e.sel    = exp_sel(cyc, en);
        e.ready  = !m_pend;
        e.data   = m_data;
        e.frame  = wrap;
        exp_q.push_back(e);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        cyc         = 0;
        m_pend      = 1'b0;
        m_pend_data = '0;
        m_data      = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel"},   32'(LED_Select),  32'(SEL_OFF));
        check({tag, "_data"},  data_out,         32'h0);
        check({tag, "_ready"}, 32'(load_ready),  32'h1);
        check({tag, "_frame"}, 32'(frame_start), 32'h0);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    // Monitor: compares every registered output once per queued cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("LED_Select",  32'(LED_Select),  32'(mon_e.sel));
            check("load_ready",  32'(load_ready),  32'(mon_e.ready));
            check("data_out",    data_out,         mon_e.data);
            check("frame_start", 32'(frame_start), 32'(mon_e.frame));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #22;
        check_reset_vals("reset");
        release_rst();

        // Full scan with all digits enabled, then load during the second frame.
        run_to(FRAME + 5);
        load_valid = 1'b1;
        load_data  = 32'h12345678;
        step();

        // Back-pressure: hold the next value until the slot frees at the wrap.
        load_data = 32'hAAAA0000;
        for (int i = 0; i < 4 * FRAME && !last_acc; i++) step();
        load_valid = 1'b0;

        // Accept coincident with the wrap tick: committed only at the following wrap.
        run_to(4 * FRAME - 1);
        load_valid = 1'b1;
        load_data  = 32'h0000BEEF;
        step();
        load_valid = 1'b0;

        // Best case: accepted one cycle before the wrap tick.
        run_to(6 * FRAME - 2);
        load_valid = 1'b1;
        load_data  = 32'h87654321;
        step();
        load_valid = 1'b0;

        // Digit mask, changed mid-slot.
        run_to(6 * FRAME + 2);
        digit_en = 8'b0000_0101;
        run_to(8 * FRAME + 6);
        digit_en = 8'hFF;
        run_to(8 * FRAME + 14);

        // Reset while a value is pending; it must never reach the display.
        load_valid = 1'b1;
        load_data  = 32'hDEADBEEF;
        step();
        load_valid = 1'b0;
        run_to(8 * FRAME + 24);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_vals("async_reset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset_hold");
        release_rst();
        run_to(2 * FRAME + 4);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_driver.md
# sevseg_scan_driver

Upstream scan sequencer for the 8-digit common-anode seven-segment display. It divides the system clock into a per-digit refresh tick and steps a digit index through 0..7. It holds a tear-free 32-bit display buffer that is updated only at frame boundaries, and drives `LED_Select`/`data_out` straight into the segment-control stage. Disabled digits and inter-digit blanking windows are signalled with the out-of-range select code. The control stage maps that code to all anodes off.

## Interface
- `REFRESH_DIV`, 100000: clocks per digit slot; legal range is 2 or more.
- `BLANK_CYCLES`, 8: cycles at the start of each slot during which all digits are off (anti-ghosting); legal range is 0 to `REFRESH_DIV`-1.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  new display value offered.
- `load_data`  in  32  eight 4-bit digits; digit n is bits [4n+3:4n].
- `load_ready`  out  1  high when the pending slot is empty.
- `digit_en`  in  8  per-digit enable; bit n enables digit n.
- `LED_Select`  out  4  {0,idx} for an active digit; `SEL_OFF`=4'b1000 when dark.
- `data_out`  out  32  committed display buffer.
- `frame_start`  out  1  one-cycle pulse when the index wraps 7→0.

## Operation
- **Prescaler**: `pcnt` counts 0..`REFRESH_DIV`-1 and then wraps. `tick` is high when `pcnt`==`REFRESH_DIV`-1.
- **Digit index**: `idx` is 3 bits. On `tick`, `idx` <= `idx`+1 mod 8.
- **Slot phase**: the slot is in its blank window while `pcnt` < `BLANK_CYCLES`. `pcnt` counts from 0 at the start of each slot.
- **Select output** (registered): `LED_Select` <= `SEL_OFF` if in the blank window or `digit_en[idx]`==0; otherwise {1'b0,`idx`}.
- **Load handshake**: a transfer occurs when `load_valid && load_ready`. The accepted value goes to the `pend_data` register, `pend` is set, and `load_ready` drops on the next cycle. A value must not be accepted while `pend`=1. `load_valid` may stay high; it is not consumed until `ready`.
- **Commit**: on a `tick` with `idx`==7 and `pend`=1, `data_out` <= `pend_data` and `pend` <= 0. `load_ready` rises on the next cycle.
- **Frame pulse**: `frame_start` is asserted for exactly one cycle on every 7→0 wrap tick, whether or not a commit occurs.
- **Simultaneous accept and wrap tick** (`pend`=0): the value is accepted into `pend` and is not committed until the following wrap. There is no bypass.
- **Enable changes**: a change on `digit_en` takes effect on the next cycle's select computation. It does not affect `idx` stepping; all 8 slots are always timed.
- **States**: IDLE, entered from reset, with `data_out`=0. IDLE moves to SCAN on the first cycle after reset deassert. SCAN stays in SCAN.
- **Reset mid-operation**: asserting reset clears everything immediately, including any pending value. The pending value is lost.

## Timing
- **Reset values**: `LED_Select`=4'b1000, `data_out`=0, `load_ready`=1, `frame_start`=0. Internal `pcnt`=0, `idx`=0, `pend`=0.
- `LED_Select` has 1-cycle latency from `pcnt`/`idx`/`digit_en`.
- `data_out` updates in the cycle after the commit tick, aligned with `frame_start` high in that same cycle. `frame_start` is registered from the tick.
- Worst-case load-to-display latency is 16×`REFRESH_DIV`+1 cycles. Best case is 1 cycle, when the load is accepted one cycle before the wrap tick.
- Frame period is 8×`REFRESH_DIV` cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `sevseg_pkg` holds:
  - `NUM_DIGITS`=8
  - `SEL_OFF`=4'b1000
  - `digit_idx_t` (3-bit)
  - `DIGIT_W`=4
- Sub-module `sevseg_prescaler` (parameter `DIV`): outputs `tick` and `pcnt`. It is reused by the future blink/brightness block.
- The top level contains the index counter, pending/commit logic, the IDLE/SCAN state register, and the output registers.

## Test plan
Benches run with `REFRESH_DIV`=4, `BLANK_CYCLES`=1.
- **Reset and scan**: release `rst`, `digit_en`=8'hFF → `LED_Select` repeats pattern `SEL_OFF`,k,k,k for k=0..7; `data_out`=0; `load_ready`=1.
- **Load and commit**: load 32'h12345678 at cycle 5 → `load_ready` goes 0 next cycle; `data_out` becomes 32'h12345678 exactly when `frame_start` pulses at the first wrap; `load_ready` returns to 1.
- **Back-pressure**: hold `load_valid` with 32'hAAAA0000 while `pend`=1 → not accepted until `load_ready`=1; committed at the next wrap, one frame after the first value.
- **Accept on wrap tick**: `load_valid` coincident with the 7→0 tick while `pend`=0 → `data_out` unchanged at that wrap; updated at the following wrap.
- **Digit mask**: `digit_en`=8'b0000_0101 → only selects 0 and 2 appear; all other slots show `SEL_OFF`; `frame_start` period remains 32 cycles.
- **Async reset mid-pending**: load 32'hDEADBEEF, then assert `rst` before the wrap → outputs go to reset values asynchronously; after release, `data_out` stays 0 through two frames.
